// File: rtl/uart_frame_loader_pkg.sv
// uart_frame_loader_pkg: FSM state encoding and default sizing shared by the frame loader
package uart_frame_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE, S_ERR} state_t;
  localparam int DEPTH_DEF = 76800;
  localparam int AW_DEF = 17;
  localparam int TMO_DEF = 1000000;
endpackage

// File: rtl/uart_frame_loader_if.sv
// uart_frame_loader_if: rx FIFO pop port and image RAM write port of the frame loader
//   rx_valid_i/rx_data_i : FWFT rx FIFO head (not empty, head byte)
//   rx_rd_o              : one-cycle pop strobe
//   ram_en_o/ram_we_o/ram_addr_o/ram_data_o : image RAM write port
//   master = loader side, slave = FIFO/RAM side
interface uart_frame_loader_if import uart_frame_loader_pkg::*; #(parameter int AW = AW_DEF);
  logic          rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          rx_rd_o;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [7:0]    ram_data_o;
  modport master (input rx_valid_i, rx_data_i, output rx_rd_o, ram_en_o, ram_we_o, ram_addr_o, ram_data_o);
  modport slave (output rx_valid_i, rx_data_i, input rx_rd_o, ram_en_o, ram_we_o, ram_addr_o, ram_data_o);
endinterface

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: pops DEPTH bytes from the UART rx FIFO into image RAM with checksum, timeout and abort
//   clk_i, rstn_i (async active-low), start_i, abort_i
//   bus        : rx FIFO pop + image RAM write port (master side)
//   busy_o     : in WAIT/WRITE      done_o   : frame complete pulse
//   loaded_o   : frame loaded       timeout_o: sticky inter-byte timeout
//   count_o    : bytes written      checksum_o: byte sum mod 256
module uart_frame_loader import uart_frame_loader_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           start_i,
  input  logic           abort_i,
  uart_frame_loader_if.master bus,
  output logic           busy_o,
  output logic           done_o,
  output logic           loaded_o,
  output logic           timeout_o,
  output logic [AW-1:0]  count_o,
  output logic [7:0]     checksum_o
);
  localparam int IW = $clog2(TMO + 1);
  state_t state, state_nx;
  logic [7:0] byte_q, byte_nx, data_nx, sum_nx;
  logic [IW-1:0] idle_q, idle_nx;
  logic [AW-1:0] addr_nx, cnt_nx;
  logic rd_nx, we_nx, busy_nx, done_nx, loaded_nx, tmo_nx;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    byte_nx = byte_q;
    idle_nx = idle_q;
    rd_nx = 1'b0;
    we_nx = 1'b0;
    addr_nx = bus.ram_addr_o;
    data_nx = bus.ram_data_o;
    done_nx = 1'b0;
    loaded_nx = loaded_o;
    tmo_nx = timeout_o;
    cnt_nx = count_o;
    sum_nx = checksum_o;
    if (abort_i) state_nx = S_IDLE;
    else
      case (state)
        S_IDLE, S_ERR:
          if (start_i) begin
            state_nx = S_WAIT;
            cnt_nx = '0;
            sum_nx = '0;
            tmo_nx = 1'b0;
            loaded_nx = 1'b0;
            idle_nx = '0;
          end
        S_WAIT:
          if (bus.rx_valid_i) begin
            rd_nx = 1'b1;
            byte_nx = bus.rx_data_i;
            idle_nx = '0;
            state_nx = S_WRITE;
          end else begin
            // saturate so an empty-frame wait can sit forever without wrapping
            idle_nx = idle_q + IW'(idle_q != IW'(TMO));
            if (idle_nx == IW'(TMO) && count_o != '0) begin
              tmo_nx = 1'b1;
              state_nx = S_ERR;
            end
          end
        S_WRITE: begin
          // RAM strobes are registered here so an abort in this cycle suppresses the write
          we_nx = 1'b1;
          addr_nx = count_o;
          data_nx = byte_q;
          cnt_nx = count_o + 1'b1;
          sum_nx = checksum_o + byte_q;
          state_nx = (count_o == AW'(DEPTH - 1)) ? S_DONE : S_WAIT;
        end
        S_DONE: begin
          done_nx = 1'b1;
          loaded_nx = 1'b1;
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    busy_nx = (state_nx == S_WAIT) || (state_nx == S_WRITE);
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      byte_q <= '0;
      idle_q <= '0;
      bus.rx_rd_o <= 1'b0;
      bus.ram_en_o <= 1'b0;
      bus.ram_we_o <= 1'b0;
      bus.ram_addr_o <= '0;
      bus.ram_data_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      loaded_o <= 1'b0;
      timeout_o <= 1'b0;
      count_o <= '0;
      checksum_o <= '0;
    end else begin
      byte_q <= byte_nx;
      idle_q <= idle_nx;
      bus.rx_rd_o <= rd_nx;
      bus.ram_en_o <= we_nx;
      bus.ram_we_o <= we_nx;
      bus.ram_addr_o <= addr_nx;
      bus.ram_data_o <= data_nx;
      busy_o <= busy_nx;
      done_o <= done_nx;
      loaded_o <= loaded_nx;
      timeout_o <= tmo_nx;
      count_o <= cnt_nx;
      checksum_o <= sum_nx;
    end
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: directed self-checking bench with rx FIFO model and RAM-write scoreboard
module tb_uart_frame_loader;
  localparam int DEPTH = 4;
  localparam int AW = 3;
  localparam int TMO = 50;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic busy_o, done_o, loaded_o, timeout_o;
  logic [AW-1:0] count_o;
  logic [7:0] checksum_o;
  uart_frame_loader_if #(.AW(AW)) bus ();
  uart_frame_loader #(.DEPTH(DEPTH), .AW(AW), .TMO(TMO)) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .start_i(start_i),
    .abort_i(abort_i),
    .bus(bus),
    .busy_o(busy_o),
    .done_o(done_o),
    .loaded_o(loaded_o),
    .timeout_o(timeout_o),
    .count_o(count_o),
    .checksum_o(checksum_o)
  );
  always #5 clk_i = ~clk_i;
  logic [7:0] rx_q[$];
  logic [AW+7:0] exp_q[$];
  int rd_cyc[$];
  logic [7:0] mem [0:2**AW-1];
  logic [AW-1:0] exp_addr;
  int passed = 0, total = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int n, rd0, w0;
  logic [7:0] a_bytes [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
  logic [7:0] r_bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_rx();
    bus.rx_valid_i = rx_q.size() != 0;
    bus.rx_data_i = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic tick();
    logic [AW+7:0] e;
    @(negedge clk_i);
    cyc++;
    if (bus.rx_rd_o) begin
      rd_cnt++;
      rd_cyc.push_back(cyc);
      if (rx_q.size() != 0) void'(rx_q.pop_front());
    end
    if (bus.ram_en_o && bus.ram_we_o) begin
      wr_cnt++;
      mem[bus.ram_addr_o] = bus.ram_data_o;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("ram_wr", 32'({bus.ram_addr_o, bus.ram_data_o}), 32'(e));
    end
    if (done_o) done_cnt++;
    drive_rx();
  endtask

  task automatic new_frame();
    exp_addr = '0;
    exp_q.delete();
  endtask

  task automatic push(input logic [7:0] b, input bit expect_wr);
    rx_q.push_back(b);
    if (expect_wr) begin
      exp_q.push_back({exp_addr, b});
      exp_addr++;
    end
    drive_rx();
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (!done_o && k < lim) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(done_o), 1);
  endtask

  task automatic wait_count(input logic [AW-1:0] c, input int lim);
    int k = 0;
    while (count_o != c && k < lim) begin
      tick();
      k++;
    end
    chk("count_reach", 32'(count_o), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i = 8'h00;
    repeat (2) tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_loaded", 32'(loaded_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_checksum", 32'(checksum_o), 0);
    chk("rst_rx_rd", 32'(bus.rx_rd_o), 0);
    chk("rst_ram_en", 32'(bus.ram_en_o), 0);
    chk("rst_ram_we", 32'(bus.ram_we_o), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr_o), 0);
    chk("rst_ram_data", 32'(bus.ram_data_o), 0);
    rstn_i = 1'b1;
    tick();
    // full frame with a continuously non-empty FIFO
    new_frame();
    for (int i = 0; i < 4; i++) push(a_bytes[i], 1'b1);
    repeat (3) tick();
    chk("no_pop_in_idle", 32'(rd_cnt), 0);
    rd_cyc.delete();
    start_frame();
    wait_done(40);
    chk("a_loaded", 32'(loaded_o), 1);
    chk("a_checksum", 32'(checksum_o), 32'h A0);
    chk("a_count", 32'(count_o), 4);
    chk("a_busy_after", 32'(busy_o), 0);
    tick();
    chk("a_done_pulse_width", 32'(done_o), 0);
    chk("a_done_count", 32'(done_cnt), 1);
    for (int i = 0; i < 4; i++) chk("a_mem", 32'(mem[i]), 32'(a_bytes[i]));
    chk("a_pops", 32'(rd_cnt), 4);
    for (int i = 1; i < rd_cyc.size(); i++) chk("a_pop_gap", 32'(rd_cyc[i] - rd_cyc[i-1]), 2);
    chk("a_sb_empty", 32'(exp_q.size()), 0);
    // checksum wrap
    new_frame();
    push(8'hFF, 1'b1);
    push(8'h02, 1'b1);
    push(8'h01, 1'b1);
    push(8'h00, 1'b1);
    start_frame();
    chk("b_loaded_cleared", 32'(loaded_o), 0);
    chk("b_busy", 32'(busy_o), 1);
    wait_done(40);
    chk("b_checksum_wrap", 32'(checksum_o), 32'h02);
    chk("b_done_count", 32'(done_cnt), 2);
    tick();
    // empty-frame wait never times out, then timeout after two bytes
    new_frame();
    start_frame();
    repeat (120) tick();
    chk("zero_cnt_no_timeout", 32'(timeout_o), 0);
    chk("zero_cnt_busy", 32'(busy_o), 1);
    push(8'h5A, 1'b1);
    wait_count(1, 10);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_ignored_count", 32'(count_o), 1);
    chk("start_ignored_busy", 32'(busy_o), 1);
    push(8'hA5, 1'b1);
    wait_count(2, 10);
    n = 0;
    while (!timeout_o && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_wait_cycles", 32'(n), 50);
    chk("tmo_flag", 32'(timeout_o), 1);
    chk("tmo_count", 32'(count_o), 2);
    chk("tmo_checksum", 32'(checksum_o), 32'h FF);
    chk("tmo_busy", 32'(busy_o), 0);
    chk("tmo_no_done", 32'(done_cnt), 2);
    rd0 = rd_cnt;
    push(8'h77, 1'b0);
    repeat (5) tick();
    chk("err_no_pop", 32'(rd_cnt), 32'(rd0));
    chk("err_count_held", 32'(count_o), 2);
    chk("err_timeout_sticky", 32'(timeout_o), 1);
    rx_q.delete();
    drive_rx();
    // abort in the WRITE cycle
    new_frame();
    start_frame();
    chk("restart_timeout_clr", 32'(timeout_o), 0);
    chk("restart_count_clr", 32'(count_o), 0);
    push(8'h11, 1'b1);
    wait_count(1, 10);
    w0 = wr_cnt;
    push(8'h55, 1'b0);
    n = 0;
    while (!bus.rx_rd_o && n < 10) begin
      tick();
      n++;
    end
    chk("abort_rd_seen", 32'(bus.rx_rd_o), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_no_ram_en", 32'(bus.ram_en_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_count_held", 32'(count_o), 1);
    chk("abort_wr_count", 32'(wr_cnt), 32'(w0));
    repeat (3) tick();
    chk("abort_no_done", 32'(done_cnt), 2);
    // reset mid-frame then reload from address 0
    new_frame();
    start_frame();
    push(8'hC1, 1'b1);
    push(8'hC2, 1'b1);
    wait_count(2, 20);
    rstn_i = 1'b0;
    #1;
    chk("arst_count", 32'(count_o), 0);
    chk("arst_checksum", 32'(checksum_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_ram_en", 32'(bus.ram_en_o), 0);
    tick();
    rstn_i = 1'b1;
    tick();
    new_frame();
    for (int i = 0; i < 4; i++) push(r_bytes[i], 1'b1);
    start_frame();
    wait_done(40);
    chk("r_checksum", 32'(checksum_o), 32'h EA);
    chk("r_count", 32'(count_o), 4);
    for (int i = 0; i < 4; i++) chk("r_mem", 32'(mem[i]), 32'(r_bytes[i]));
    chk("r_sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_frame_loader.md
UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 Parameter DEPTH, default 76800, bytes per frame.
REQ-002 Parameter AW, default 17, RAM address width; 2**AW SHALL be >= DEPTH.
REQ-003 Parameter TMO, default 1000000, idle clock cycles between bytes before timeout.
REQ-004 clk_i  input  1  single clock, rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  level or pulse; starts a frame load when sampled high in IDLE.
REQ-007 abort_i  input  1  cancels the load in progress.
REQ-008 rx_valid_i  input  1  UART rx FIFO not empty; first-word-fall-through, so rx_data_i is valid while high.
REQ-009 rx_data_i  input  8  head byte of the rx FIFO.
REQ-010 rx_rd_o  output  1  one-cycle pop strobe to the rx FIFO.
REQ-011 ram_en_o, ram_we_o  output  1 each  image RAM enable and write enable.
REQ-012 ram_addr_o  output  AW  image RAM address.
REQ-013 ram_data_o  output  8  image RAM write data.
REQ-014 busy_o  output  1  high while in WAIT or WRITE.
REQ-015 done_o  output  1  one-cycle pulse when the frame is complete.
REQ-016 loaded_o  output  1  high from completion until the next accepted start_i.
REQ-017 timeout_o  output  1  sticky timeout flag.
REQ-018 count_o  output  AW  number of bytes written in the current frame.
REQ-019 checksum_o  output  8  running byte sum of the current frame.

Function
REQ-020 FSM states SHALL be IDLE, WAIT, WRITE, DONE and ERR; all outputs SHALL be registered.
REQ-021 IDLE + start_i: clear count_o, checksum_o, timeout_o, loaded_o and the idle counter; go to WAIT.
REQ-022 WAIT + rx_valid_i: rx_rd_o=1 for exactly one cycle; capture rx_data_i; go to WRITE.
REQ-023 WRITE: one cycle with ram_en_o=1, ram_we_o=1, ram_addr_o=count_o, ram_data_o=captured byte; count_o+1; checksum_o += byte, modulo 256.
REQ-024 WRITE exit: if the pre-increment count_o equals DEPTH-1, go to DONE; otherwise go to WAIT.
REQ-025 Throughput SHALL be at most one byte per 2 cycles; a byte SHALL be in RAM 2 cycles after its pop.
REQ-026 DONE: done_o=1 for one cycle; loaded_o=1; go to IDLE.
REQ-027 Outside WRITE: ram_we_o=0 and ram_en_o=0; rx_rd_o=0 outside the WAIT pop cycle.
REQ-028 Idle counter: increments in WAIT while rx_valid_i=0; clears on every pop.
REQ-029 Timeout: when the idle counter reaches TMO and count_o > 0, set timeout_o and go to ERR; a count_o==0 wait SHALL never time out.
REQ-030 ERR: hold count_o and checksum_o; leave only on start_i (same as REQ-021) or reset.
REQ-031 abort_i has priority over every other event in any state: go to IDLE next cycle; no done_o; RAM writes stop immediately; count_o is held.
REQ-032 start_i in WAIT, WRITE or DONE SHALL be ignored.
REQ-033 rx_valid_i in IDLE, DONE or ERR SHALL not cause a pop; bytes stay in the FIFO.
REQ-034 The count_o compare SHALL be AW bits wide; count_o SHALL never exceed DEPTH.

Reset
REQ-035 rstn_i low: state=IDLE and all outputs 0, including count_o and checksum_o, asynchronously.
REQ-036 Reset mid-frame discards progress; RAM contents are not cleared.

Structure
REQ-037 The state encoding and the DEPTH/AW defaults SHALL be in a shared package also used by the top level.
REQ-038 The block SHALL be a single module with no sub-modules; it connects between uart_rx_top and the first image ram instance.

Verification
REQ-039 DEPTH=4, start, then bytes 0x10, 0x20, 0x30, 0x40 -> RAM[0..3] equal those bytes, checksum_o=0xA0, one done_o pulse, loaded_o=1.
REQ-040 DEPTH=3, bytes 0xFF, 0x02, 0x01 -> checksum_o=0x02 (wraps).
REQ-041 TMO=50, two bytes then silence -> timeout_o=1 after 50 WAIT cycles, count_o=2, no done_o.
REQ-042 abort_i in the same cycle as a WRITE -> no RAM write that cycle, state IDLE next cycle, busy_o=0.
REQ-043 rstn_i low mid-frame at count_o=2 -> all outputs 0 immediately; a new start_i reloads from address 0.
REQ-044 rx_valid_i held high continuously, DEPTH=4 -> exactly 4 rx_rd_o pulses, 2 cycles apart.
